// File: rtl/cwe1234_locked_reader_if.sv
// Bus bundle for the locked register reader: provisioning, lock pulses,
// debug indication, and the read request/response channel.
interface cwe1234_locked_reader_if;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [15:0] load_data;
  logic [3:0]  Lock;
  logic        debug_unlocked;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        rd_busy;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_denied;
  logic [7:0]  deny_count;
  logic [3:0]  lock_status;

  modport master (
    output load_en, load_addr, load_data, Lock, debug_unlocked, rd_req, rd_addr,
    input  rd_busy, rd_valid, rd_data, rd_denied, deny_count, lock_status
  );

  modport slave (
    input  load_en, load_addr, load_data, Lock, debug_unlocked, rd_req, rd_addr,
    output rd_busy, rd_valid, rd_data, rd_denied, deny_count, lock_status
  );
endinterface

// File: rtl/cwe1234_locked_reader.sv
// Four-entry provisioned register bank with sticky per-entry read/write locks
// and a three-state read engine; DEBUG_BYPASS=1 lets debug mode override read locks.
module cwe1234_locked_reader #(
  parameter bit DEBUG_BYPASS = 1'b1
) (
  input  logic                            Clk,
  input  logic                            reset,
  cwe1234_locked_reader_if.slave          bus
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_bank [4];
  logic [3:0]          r_lock;
  logic [1:0]          r_addr;
  logic                r_allowed_p0;
  logic [DATA_W-1:0]   r_data_p0;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_denied;
  logic [7:0]          r_deny_cnt;

  logic                w_load_ok;
  logic                w_allowed;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A lock pulse in the same cycle as a load already blocks that load.
  assign w_load_ok = bus.load_en & ~r_lock[bus.load_addr] & ~bus.Lock[bus.load_addr];
  assign w_allowed = ~r_lock[r_addr] | (DEBUG_BYPASS & bus.debug_unlocked);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < 4; i++) r_bank[i] <= '0;
      r_lock       <= '0;
      r_addr       <= '0;
      r_allowed_p0 <= 1'b0;
      r_data_p0    <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_denied     <= 1'b0;
      r_deny_cnt   <= '0;
    end else begin
      r_lock  <= r_lock | bus.Lock;
      if (w_load_ok) r_bank[bus.load_addr] <= bus.load_data;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_denied <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.rd_req) begin
            r_addr  <= bus.rd_addr;
            r_state <= S_CHECK;
          end
        end
        // p0: lock decision and bank snapshot taken from CHECK-cycle values
        S_CHECK: begin
          r_allowed_p0 <= w_allowed;
          r_data_p0    <= r_bank[r_addr];
          r_state      <= S_RESP;
        end
        // response registered out on the edge leaving RESP
        S_RESP: begin
          r_valid <= 1'b1;
          if (r_allowed_p0) begin
            r_data <= r_data_p0;
          end else begin
            r_denied   <= 1'b1;
            r_deny_cnt <= sat_inc(r_deny_cnt);
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_busy     = (r_state != S_IDLE);
  assign bus.rd_valid    = r_valid;
  assign bus.rd_data     = r_data;
  assign bus.rd_denied   = r_denied;
  assign bus.deny_count  = r_deny_cnt;
  assign bus.lock_status = r_lock;

endmodule

// File: tb/tb_cwe1234_locked_reader.sv
// Directed bench: drives one stimulus stream into a DEBUG_BYPASS=1 and a
// DEBUG_BYPASS=0 instance side by side and checks both against hand values.
module tb_cwe1234_locked_reader;

  logic        Clk;
  logic        reset;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [15:0] load_data;
  logic [3:0]  Lock;
  logic        debug_unlocked;
  logic        rd_req;
  logic [1:0]  rd_addr;

  int n_chk;
  int n_pass;

  cwe1234_locked_reader_if if1 ();
  cwe1234_locked_reader_if if0 ();

  assign if1.load_en = load_en;            assign if0.load_en = load_en;
  assign if1.load_addr = load_addr;        assign if0.load_addr = load_addr;
  assign if1.load_data = load_data;        assign if0.load_data = load_data;
  assign if1.Lock = Lock;                  assign if0.Lock = Lock;
  assign if1.debug_unlocked = debug_unlocked; assign if0.debug_unlocked = debug_unlocked;
  assign if1.rd_req = rd_req;              assign if0.rd_req = rd_req;
  assign if1.rd_addr = rd_addr;            assign if0.rd_addr = rd_addr;

  cwe1234_locked_reader #(.DEBUG_BYPASS(1'b1)) dut1 (.Clk(Clk), .reset(reset), .bus(if1));
  cwe1234_locked_reader #(.DEBUG_BYPASS(1'b0)) dut0 (.Clk(Clk), .reset(reset), .bus(if0));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues a one-cycle request and returns the response of both instances.
  task automatic do_read(input string tag, input logic [1:0] a, input logic dbg,
                         output logic [15:0] d1, output logic [15:0] d0,
                         output logic n1, output logic n0);
    rd_req = 1'b1; rd_addr = a; debug_unlocked = dbg;
    step();
    chk({tag, ".busy1"}, 32'(if1.rd_busy), 32'd1);
    chk({tag, ".busy0"}, 32'(if0.rd_busy), 32'd1);
    rd_req = 1'b0;
    step();
    chk({tag, ".early_valid"}, 32'(if1.rd_valid), 32'd0);
    step();
    chk({tag, ".valid1"}, 32'(if1.rd_valid), 32'd1);
    chk({tag, ".valid0"}, 32'(if0.rd_valid), 32'd1);
    d1 = if1.rd_data; d0 = if0.rd_data; n1 = if1.rd_denied; n0 = if0.rd_denied;
    step();
    chk({tag, ".valid_drop"}, 32'(if1.rd_valid), 32'd0);
    chk({tag, ".data_idle"}, 32'(if1.rd_data), 32'd0);
    chk({tag, ".denied_idle"}, 32'(if0.rd_denied), 32'd0);
    debug_unlocked = 1'b0;
  endtask

  initial begin
    logic [15:0] d1, d0;
    logic        n1, n0;
    int          nv1, nv0;
    n_chk = 0; n_pass = 0;
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; Lock = '0;
    debug_unlocked = 1'b0; rd_req = 1'b0; rd_addr = '0;

    #1 reset = 1'b1;
    #1;
    chk("rst.valid", 32'(if1.rd_valid), 32'd0);
    chk("rst.data", 32'(if1.rd_data), 32'd0);
    chk("rst.lock", 32'(if1.lock_status), 32'd0);
    chk("rst.deny", 32'(if0.deny_count), 32'd0);
    chk("rst.busy", 32'(if1.rd_busy), 32'd0);
    step(); step();
    reset = 1'b0;

    // Unlocked load and read
    load_en = 1'b1; load_addr = 2'd1; load_data = 16'hBEEF;
    step();
    load_en = 1'b0;
    do_read("rd_open", 2'd1, 1'b0, d1, d0, n1, n0);
    chk("rd_open.data1", 32'(d1), 32'hBEEF);
    chk("rd_open.data0", 32'(d0), 32'hBEEF);
    chk("rd_open.den1", 32'(n1), 32'd0);

    // Lock addr1, blocked reload, locked read
    Lock = 4'b0010;
    step();
    Lock = 4'b0000;
    chk("lock1.status", 32'(if1.lock_status), 32'h2);
    load_en = 1'b1; load_addr = 2'd1; load_data = 16'h1234;
    step();
    load_en = 1'b0;
    do_read("rd_lock", 2'd1, 1'b0, d1, d0, n1, n0);
    chk("rd_lock.data1", 32'(d1), 32'h0);
    chk("rd_lock.den1", 32'(n1), 32'd1);
    chk("rd_lock.den0", 32'(n0), 32'd1);
    chk("rd_lock.cnt1", 32'(if1.deny_count), 32'd1);
    chk("rd_lock.cnt0", 32'(if0.deny_count), 32'd1);

    // Debug override: only the bypass instance leaks the stored value
    do_read("rd_dbg", 2'd1, 1'b1, d1, d0, n1, n0);
    chk("rd_dbg.data1", 32'(d1), 32'hBEEF);
    chk("rd_dbg.den1", 32'(n1), 32'd0);
    chk("rd_dbg.data0", 32'(d0), 32'h0);
    chk("rd_dbg.den0", 32'(n0), 32'd1);
    chk("rd_dbg.cnt1", 32'(if1.deny_count), 32'd1);
    chk("rd_dbg.cnt0", 32'(if0.deny_count), 32'd2);

    // Lock pulse in the same cycle as a load to that entry blocks the load
    load_en = 1'b1; load_addr = 2'd2; load_data = 16'hAAAA; Lock = 4'b0100;
    step();
    load_en = 1'b0; Lock = 4'b0000;
    chk("lock2.status", 32'(if1.lock_status), 32'h6);
    do_read("rd_same", 2'd2, 1'b1, d1, d0, n1, n0);
    chk("rd_same.data1", 32'(d1), 32'h0);
    chk("rd_same.den1", 32'(n1), 32'd0);
    chk("rd_same.den0", 32'(n0), 32'd1);
    chk("rd_same.cnt0", 32'(if0.deny_count), 32'd3);

    // Lock raised during CHECK does not affect the in-flight read
    load_en = 1'b1; load_addr = 2'd3; load_data = 16'h5555;
    step();
    load_en = 1'b0;
    rd_req = 1'b1; rd_addr = 2'd3; debug_unlocked = 1'b0;
    step();
    rd_req = 1'b0; Lock = 4'b1000;
    step();
    Lock = 4'b0000;
    chk("chklock.status", 32'(if1.lock_status), 32'hE);
    step();
    chk("chklock.valid", 32'(if0.rd_valid), 32'd1);
    chk("chklock.data1", 32'(if1.rd_data), 32'h5555);
    chk("chklock.data0", 32'(if0.rd_data), 32'h5555);
    chk("chklock.den0", 32'(if0.rd_denied), 32'd0);
    step();
    do_read("rd_l3", 2'd3, 1'b0, d1, d0, n1, n0);
    chk("rd_l3.den1", 32'(n1), 32'd1);
    chk("rd_l3.cnt1", 32'(if1.deny_count), 32'd2);
    chk("rd_l3.cnt0", 32'(if0.deny_count), 32'd4);

    // 300 back-to-back denied reads with the request held high throughout
    nv1 = 0; nv0 = 0;
    rd_req = 1'b1; rd_addr = 2'd1; debug_unlocked = 1'b0;
    for (int i = 0; i < 900; i++) begin
      step();
      if (if1.rd_valid === 1'b1) nv1++;
      if (if0.rd_valid === 1'b1) nv0++;
    end
    rd_req = 1'b0;
    chk("bulk.nresp1", 32'(nv1), 32'd300);
    chk("bulk.nresp0", 32'(nv0), 32'd300);
    chk("bulk.cnt1", 32'(if1.deny_count), 32'hFF);
    chk("bulk.cnt0", 32'(if0.deny_count), 32'hFF);
    step();
    chk("bulk.idle", 32'(if1.rd_busy), 32'd0);

    // Reset while a read sits in CHECK
    rd_req = 1'b1; rd_addr = 2'd1;
    step();
    rd_req = 1'b0;
    chk("abort.in_check", 32'(if1.rd_busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort.busy", 32'(if1.rd_busy), 32'd0);
    chk("abort.valid", 32'(if1.rd_valid), 32'd0);
    chk("abort.lock", 32'(if1.lock_status), 32'd0);
    chk("abort.cnt1", 32'(if1.deny_count), 32'd0);
    chk("abort.cnt0", 32'(if0.deny_count), 32'd0);
    step();
    chk("abort.no_resp", 32'(if1.rd_valid), 32'd0);
    reset = 1'b0;
    do_read("rd_post", 2'd1, 1'b0, d1, d0, n1, n0);
    chk("rd_post.data1", 32'(d1), 32'h0);
    chk("rd_post.den1", 32'(n1), 32'd0);
    chk("rd_post.den0", 32'(n0), 32'd0);
    chk("rd_post.cnt0", 32'(if0.deny_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cwe1234_locked_reader.md
CWE1234_LOCKED_READER -- requirements
Module: cwe1234_locked_reader

Interface
REQ-001 Parameter: DEBUG_BYPASS, default 1, meaning debug_unlocked overrides read locks when 1 (vulnerable CWE-1234 form) and is ignored when 0 (safe form).
REQ-002 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: load_en  input  1  provisioning write strobe.
REQ-005 Port: load_addr  input  2  provisioning target register.
REQ-006 Port: load_data  input  16  provisioning write data.
REQ-007 Port: Lock  input  4  per-register lock-set pulses.
REQ-008 Port: debug_unlocked  input  1  debug-mode indication.
REQ-009 Port: rd_req  input  1  read request.
REQ-010 Port: rd_addr  input  2  read target register.
REQ-011 Port: rd_busy  output  1  read in progress; new requests ignored.
REQ-012 Port: rd_valid  output  1  one-cycle read response strobe.
REQ-013 Port: rd_data  output  16  read response data.
REQ-014 Port: rd_denied  output  1  response was refused by lock check; valid with rd_valid.
REQ-015 Port: deny_count  output  8  saturating count of denied reads.
REQ-016 Port: lock_status  output  4  current sticky lock bits.

Function
REQ-017 Block SHALL hold a 4 x 16-bit register bank, written only via load port.
REQ-018 lock_status[i] SHALL set on the edge after Lock[i]=1 and clear only on reset.
REQ-019 Load SHALL update bank[load_addr] only if lock_status[load_addr]=0 and Lock[load_addr]=0 in the same cycle; debug_unlocked never affects loads.
REQ-020 Read FSM SHALL have states IDLE, CHECK, RESP; rd_busy=1 in CHECK and RESP.
REQ-021 IDLE: rd_req=1 SHALL capture rd_addr and move to CHECK; otherwise stay in IDLE.
REQ-022 rd_req while busy SHALL be ignored, not queued.
REQ-023 CHECK SHALL compute allowed = ~lock_status[addr] | (DEBUG_BYPASS & debug_unlocked), using values present in the CHECK cycle, then move to RESP.
REQ-024 RESP SHALL assert rd_valid for exactly one cycle, then return to IDLE.
REQ-025 Latency: request sampled on edge N, rd_valid high in the cycle after edge N+2, and next request accepted on edge N+3.
REQ-026 If allowed, rd_data SHALL be bank[addr] as held before any load completing on the CHECK-to-RESP edge; rd_denied=0.
REQ-027 If not allowed, rd_data SHALL be 16'h0000, rd_denied=1, and deny_count SHALL increment by 1, saturating at 8'hFF.
REQ-028 Outside RESP, rd_data SHALL be 16'h0000 and rd_denied 0.
REQ-029 A lock set during CHECK SHALL NOT affect that read; a lock set at or before the edge entering CHECK SHALL.
REQ-030 Lock, load and read activity in the same cycle SHALL all proceed independently per REQ-018/019/023.

Reset
REQ-031 Reset assertion SHALL immediately clear bank, lock_status, deny_count, rd_valid, rd_data and rd_denied to 0 and force the FSM to IDLE, aborting any read without a response.
REQ-032 After reset deasserts, the first rising edge SHALL accept rd_req normally.

Verification
REQ-033 Load addr1 = 16'hBEEF; read addr1 -> rd_valid two cycles after request, rd_data=16'hBEEF, rd_denied=0.
REQ-034 Lock[1] pulse, then load addr1 = 16'h1234 -> bank keeps 16'hBEEF; read addr1 with debug_unlocked=0 -> rd_data=0, rd_denied=1, deny_count=1.
REQ-035 Same as REQ-034 with debug_unlocked=1: DEBUG_BYPASS=1 -> rd_data=16'hBEEF, rd_denied=0; DEBUG_BYPASS=0 -> denied, deny_count increments.
REQ-036 300 denied reads back-to-back -> deny_count holds 8'hFF; requests asserted during CHECK/RESP produce no extra responses.
REQ-037 Assert reset while in CHECK -> no rd_valid, lock_status=0, deny_count=0; read of addr1 after release -> rd_data=0, rd_denied=0.
